matrix_alu: RTL and testbench
=============================

// Module: matrix_alu
// PURPOSE
// - Matrix arithmetic unit of the coprocessor: operates on two 5x5 signed 8-bit matrices and a signed 8-bit scalar.
// - Ops: add, subtract, matrix multiply, scalar multiply, transpose, negate, and a sequential 5x5 determinant.
// - Sits between the coprocessor control FSM and its 128x16 operand RAM; the RAM is a separate block, not part of this module.
// PARAMETERS
// - N      5  matrix dimension; fixed, only 5 supported
// - EW     8  element width in bits, two's complement
// - DETW  48  internal determinant precision in bits
// PORTS
// - clk           in   1    single clock; all state updates on rising edge
// - rst           in   1    reset; asynchronous, active-high
// - start         in   1    level request to run a determinant
// - op_code       in   3    operation select
// - matrix_a      in   200  matrix A; element i = row*5+col at bits [8i+7:8i]
// - matrix_b      in   200  matrix B; same packing as matrix_a
// - scalar        in   8    signed scalar for op 011
// - result_final  out  200  result matrix; same packing as inputs
// - overflow      out  1    any result element outside [-128,127]
// BEHAVIOUR
// - Op codes:
//   - 000: A+B.
//   - 001: A-B.
//   - 010: A x B, each element a 5-term dot product accumulated at 20 bits.
//   - 011: scalar*A.
//   - 100: transpose A, so out[r][c]=A[c][r].
//   - 101: -A.
//   - 110: det(A).
//   - 111: result 0, overflow 0.
// - Ops 000-101 are purely combinational: zero latency, independent of start and rst.
// - Width rule: compute each element exactly at full width, emit the low 8 bits (wrap, no saturation).
// - overflow = OR over all 25 elements of (exact value < -128 or > 127).
// - Negating -128 sets overflow and outputs 0x80.
// - Op 110 output: result_final[7:0] = low 8 bits of det.
//   - result_final[199:8] = 0.
//   - overflow = det outside [-128,127].
//   - Source is the det result register, which shows 0 until the first computation completes.
// - Determinant FSM states: IDLE, LOAD, ELIM, DONE.
//   - IDLE: on start=1 -> LOAD.
//   - LOAD: capture matrix_a into internal DETW-bit work array -> ELIM.
//   - ELIM: exact integer elimination, e.g. fraction-free Bareiss.
//     - On a zero pivot, swap with a lower row that has a nonzero pivot column entry, and negate the sign.
//     - If no nonzero pivot is found, det=0 and the FSM ends early.
//     - At most one elimination step per cycle block; total ELIM cycles <= 60.
//     - At the end, write det to the result register -> DONE.
//   - DONE: hold the result; return to IDLE when start=0.
//     - Holding start high does not restart the computation.
// - Latency: the det result is valid no later than 64 cycles after start is first sampled high in IDLE.
//   - The control FSM waits 70 cycles before reading it.
// - matrix_a changes after LOAD do not affect a run already in progress.
// - op_code changes mid-run do not abort the FSM; they only change the output mux selection.
// - rst asserted at any time, including mid-ELIM:
//   - FSM -> IDLE immediately.
//   - Work array and det result register cleared to 0.
//   - Any in-progress run is discarded.
// - start pulses while in LOAD or ELIM are ignored.
// TESTING
// - Common stimulus: A[i]=i+1 for i=0..24, B all 1, scalar=3.
// - op 000 -> elem0=2, elem24=26, ovf=0.
// - op 001 -> elem i = i (elem0=0, elem24=24), ovf=0.
// - op 010 -> rows equal 15, 40, 65, 90, 115 in every column, ovf=0.
// - op 011 -> elem0=3, elem24=75.
// - op 100 -> elem1=6, elem5=2.
// - op 101 -> elem0=0xFF.
// - All with ovf=0.
// - op 110, common stimulus with start held high 70 cycles -> result_final=0 (rank-2 matrix), ovf=0.
// - op 110, A=2*I -> 32.
// - op 110, A=4*I -> 1024: low byte 0x00, ovf=1.
// - op 110, A = I with rows 0 and 1 swapped -> 0xFF (-1), exercising the pivot swap.
// - Overflow case: op 000 with A all 127 and B all 1 -> every elem 0x80, ovf=1.
// - Overflow case: op 101 with A elem0=-128 -> ovf=1.
// - Assert rst at cycle 10 of a det run -> result 0, FSM IDLE.
// - After rst, re-raise start -> correct det within 64 cycles.

Source files
------------

// File: rtl/matrix_alu_if.sv
// Operand/result bundle between the coprocessor control FSM and the matrix ALU.
interface matrix_alu_if #(
    parameter int N  = 5,
    parameter int EW = 8
);
    logic                start;
    logic [2:0]          op_code;
    logic [N*N*EW-1:0]   matrix_a;
    logic [N*N*EW-1:0]   matrix_b;
    logic [EW-1:0]       scalar;
    logic [N*N*EW-1:0]   result_final;
    logic                overflow;

    modport master (
        output start, op_code, matrix_a, matrix_b, scalar,
        input  result_final, overflow
    );

    modport slave (
        input  start, op_code, matrix_a, matrix_b, scalar,
        output result_final, overflow
    );
endinterface

// File: rtl/matrix_alu.sv
// 5x5 signed matrix ALU: combinational element-wise/product ops plus a
// sequential fraction-free (Bareiss) determinant with row-swap pivoting.
module matrix_alu #(
    parameter int N    = 5,
    parameter int EW   = 8,
    parameter int DETW = 48
) (
    input  logic          clk,
    input  logic          rst,
    matrix_alu_if.slave   bus
);
    localparam int ACCW = 20;
    localparam int WW   = 2 * DETW;
    localparam int MW   = N * N * EW;
    localparam logic [2:0] LAST = 3'(N - 1);
    localparam logic signed [ACCW-1:0] EMAX = ACCW'((1 << (EW - 1)) - 1);
    localparam logic signed [ACCW-1:0] EMIN = ~EMAX;
    localparam logic signed [DETW-1:0] DMAX = DETW'(EMAX);
    localparam logic signed [DETW-1:0] DMIN = ~DMAX;

    typedef enum logic [1:0] {IDLE, LOAD, ELIM, DONE} state_t;

    state_t state, state_next;
    logic signed [DETW-1:0] work [N][N];
    logic signed [DETW-1:0] prev, det_reg;
    logic [2:0] k, i, j;
    logic neg, pivot_ok;

    logic signed [DETW-1:0] piv, new_val;
    logic signed [WW-1:0]   num, quo;
    logic [2:0]             swap_row;
    logic                   found, last_update, no_pivot, elim_done;

    // Pivot search: first row below k with a nonzero entry in column k.
    always_comb begin
        found    = 1'b0;
        swap_row = k;
        for (int unsigned r = 0; r < N; r++) begin
            if (!found && r > 32'(k) && work[r][k] != '0) begin
                found    = 1'b1;
                swap_row = 3'(r);
            end
        end
    end

    // One Bareiss update per cycle; the product needs double width before the exact divide.
    always_comb begin
        piv     = work[k][k];
        num     = WW'(work[i][j]) * WW'(piv) - WW'(work[i][k]) * WW'(work[k][j]);
        quo     = num / WW'(prev);
        new_val = quo[DETW-1:0];
        last_update = pivot_ok && i == LAST && j == LAST && k == LAST - 3'd1;
        no_pivot    = !pivot_ok && piv == '0 && !found;
        elim_done   = last_update || no_pivot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    state_next = ELIM;
            ELIM:    if (elim_done) state_next = DONE;
            DONE:    if (!bus.start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    work[r][c] <= '0;
            prev     <= '0;
            det_reg  <= '0;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            neg      <= 1'b0;
            pivot_ok <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    for (int unsigned r = 0; r < N; r++)
                        for (int unsigned c = 0; c < N; c++)
                            work[r][c] <= DETW'(signed'(bus.matrix_a[EW*(r*N+c) +: EW]));
                    prev     <= DETW'(1);
                    k        <= '0;
                    neg      <= 1'b0;
                    pivot_ok <= 1'b0;
                end
                ELIM: begin
                    if (!pivot_ok) begin
                        if (piv != '0 || found) begin
                            pivot_ok <= 1'b1;
                            i        <= k + 3'd1;
                            j        <= k + 3'd1;
                        end else begin
                            det_reg <= '0;
                        end
                        if (piv == '0 && found) begin
                            for (int unsigned c = 0; c < N; c++) begin
                                work[k][c]        <= work[swap_row][c];
                                work[swap_row][c] <= work[k][c];
                            end
                            neg <= ~neg;
                        end
                    end else begin
                        work[i][j] <= new_val;
                        if (j == LAST) begin
                            if (i == LAST) begin
                                if (k == LAST - 3'd1) begin
                                    det_reg <= neg ? -new_val : new_val;
                                end else begin
                                    prev     <= piv;
                                    k        <= k + 3'd1;
                                    pivot_ok <= 1'b0;
                                end
                            end else begin
                                i <= i + 3'd1;
                                j <= k + 3'd1;
                            end
                        end else begin
                            j <= j + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [MW-1:0]          res;
    logic                   ovf;
    logic signed [ACCW-1:0] val, a_el, b_el, s_el;

    always_comb begin
        res  = '0;
        ovf  = 1'b0;
        val  = '0;
        a_el = '0;
        b_el = '0;
        s_el = ACCW'(signed'(bus.scalar));
        for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
                a_el = ACCW'(signed'(bus.matrix_a[EW*(r*N+c) +: EW]));
                b_el = ACCW'(signed'(bus.matrix_b[EW*(r*N+c) +: EW]));
                val  = '0;
                case (bus.op_code)
                    3'b000: val = a_el + b_el;
                    3'b001: val = a_el - b_el;
                    3'b010: begin
                        for (int unsigned t = 0; t < N; t++)
                            val = val + ACCW'(signed'(bus.matrix_a[EW*(r*N+t) +: EW]))
                                      * ACCW'(signed'(bus.matrix_b[EW*(t*N+c) +: EW]));
                    end
                    3'b011: val = a_el * s_el;
                    3'b100: val = ACCW'(signed'(bus.matrix_a[EW*(c*N+r) +: EW]));
                    3'b101: val = -a_el;
                    default: val = '0;
                endcase
                res[EW*(r*N+c) +: EW] = val[EW-1:0];
                if (val > EMAX || val < EMIN) ovf = 1'b1;
            end
        end
        if (bus.op_code == 3'b110) begin
            res         = '0;
            res[EW-1:0] = det_reg[EW-1:0];
            ovf         = det_reg > DMAX || det_reg < DMIN;
        end
    end

    assign bus.result_final = res;
    assign bus.overflow     = ovf;
endmodule

// File: tb/tb_matrix_alu.sv
// Directed self-checking bench for matrix_alu: combinational ops, overflow, determinant FSM.
module tb_matrix_alu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_alu_if #(.N(5), .EW(8)) bus();
    matrix_alu #(.N(5), .EW(8), .DETW(48)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [199:0] common_a, ones_b, exp_v;

    function automatic logic [199:0] diag(input logic [7:0] v);
        logic [199:0] m = '0;
        for (int n = 0; n < 5; n++) m[8*(n*6) +: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] swapped_identity();
        logic [199:0] m = '0;
        m[8*1 +: 8]  = 8'd1;
        m[8*5 +: 8]  = 8'd1;
        m[8*12 +: 8] = 8'd1;
        m[8*18 +: 8] = 8'd1;
        m[8*24 +: 8] = 8'd1;
        return m;
    endfunction

    task automatic drive_det(input logic [199:0] m);
        bus.matrix_a = m;
        bus.op_code  = 3'b110;
        @(negedge clk) bus.start = 1'b1;
        repeat (70) @(posedge clk);
        #1;
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op_code = 3'b110;
        bus.matrix_a = common_a;
        bus.matrix_b = ones_b;
        bus.scalar = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.result_final !== 200'd0) $display("FAIL reset_result got=%h exp=0", bus.result_final);
        else pass_cnt++;
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.overflow);
        else pass_cnt++;
        // Combinational ops stay live while reset is held.
        bus.op_code = 3'b000;
        #1;
        for (int n = 0; n < 25; n++) exp_v[8*n +: 8] = 8'(n + 2);
        total_cnt++;
        if (bus.result_final !== exp_v) $display("FAIL add_in_reset got=%h exp=%h", bus.result_final, exp_v);
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_add();
        bus.op_code = 3'b000; bus.matrix_a = common_a; bus.matrix_b = ones_b;
        #1;
        for (int n = 0; n < 25; n++) exp_v[8*n +: 8] = 8'(n + 2);
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b0)
            $display("FAIL add got=%h ovf=%b exp=%h ovf=0", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_sub();
        bus.op_code = 3'b001;
        #1;
        for (int n = 0; n < 25; n++) exp_v[8*n +: 8] = 8'(n);
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b0)
            $display("FAIL sub got=%h ovf=%b exp=%h ovf=0", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_matmul();
        bus.op_code = 3'b010;
        #1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) exp_v[8*(r*5+c) +: 8] = 8'(25*r + 15);
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b0)
            $display("FAIL matmul got=%h ovf=%b exp=%h ovf=0", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_scalar();
        bus.op_code = 3'b011;
        #1;
        for (int n = 0; n < 25; n++) exp_v[8*n +: 8] = 8'(3 * (n + 1));
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b0)
            $display("FAIL scalar got=%h ovf=%b exp=%h ovf=0", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_transpose();
        bus.op_code = 3'b100;
        #1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) exp_v[8*(r*5+c) +: 8] = 8'(c*5 + r + 1);
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b0)
            $display("FAIL transpose got=%h ovf=%b exp=%h ovf=0", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_negate();
        logic [7:0] t;
        bus.op_code = 3'b101;
        #1;
        for (int n = 0; n < 25; n++) begin
            t = 8'(n + 1);
            exp_v[8*n +: 8] = -t;
        end
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b0)
            $display("FAIL negate got=%h ovf=%b exp=%h ovf=0", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_op_zero();
        bus.op_code = 3'b111;
        #1;
        total_cnt++;
        if (bus.result_final !== 200'd0 || bus.overflow !== 1'b0)
            $display("FAIL op111 got=%h ovf=%b exp=0 ovf=0", bus.result_final, bus.overflow);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        bus.op_code = 3'b000;
        for (int n = 0; n < 25; n++) bus.matrix_a[8*n +: 8] = 8'h7F;
        bus.matrix_b = ones_b;
        #1;
        for (int n = 0; n < 25; n++) exp_v[8*n +: 8] = 8'h80;
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b1)
            $display("FAIL add_ovf got=%h ovf=%b exp=%h ovf=1", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
        bus.op_code = 3'b101;
        bus.matrix_a = '0;
        bus.matrix_a[7:0] = 8'h80;
        #1;
        exp_v = '0;
        exp_v[7:0] = 8'h80;
        total_cnt++;
        if (bus.result_final !== exp_v || bus.overflow !== 1'b1)
            $display("FAIL neg_ovf got=%h ovf=%b exp=%h ovf=1", bus.result_final, bus.overflow, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_det_rank2();
        drive_det(common_a);
        total_cnt++;
        if (bus.result_final !== 200'd0 || bus.overflow !== 1'b0)
            $display("FAIL det_rank2 got=%h ovf=%b exp=0 ovf=0", bus.result_final, bus.overflow);
        else pass_cnt++;
        release_start();
    endtask

    task automatic test_det_2i_input_change();
        bus.matrix_a = diag(8'd2);
        bus.op_code  = 3'b110;
        @(negedge clk) bus.start = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.matrix_a = diag(8'd4);
        repeat (66) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.result_final !== 200'd32 || bus.overflow !== 1'b0)
            $display("FAIL det_2i got=%h ovf=%b exp=20 ovf=0", bus.result_final, bus.overflow);
        else pass_cnt++;
        release_start();
    endtask

    task automatic test_det_4i();
        drive_det(diag(8'd4));
        total_cnt++;
        if (bus.result_final !== 200'd0 || bus.overflow !== 1'b1)
            $display("FAIL det_4i got=%h ovf=%b exp=0 ovf=1", bus.result_final, bus.overflow);
        else pass_cnt++;
        release_start();
    endtask

    task automatic test_det_swap();
        drive_det(swapped_identity());
        total_cnt++;
        if (bus.result_final !== 200'hFF || bus.overflow !== 1'b0)
            $display("FAIL det_swap got=%h ovf=%b exp=ff ovf=0", bus.result_final, bus.overflow);
        else pass_cnt++;
        release_start();
    endtask

    task automatic test_reset_mid_run();
        logic got;
        bus.matrix_a = diag(8'd2);
        bus.op_code  = 3'b110;
        @(negedge clk) bus.start = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        bus.start = 1'b0;
        #1;
        total_cnt++;
        if (bus.result_final !== 200'd0 || bus.overflow !== 1'b0)
            $display("FAIL rst_mid_run got=%h ovf=%b exp=0 ovf=0", bus.result_final, bus.overflow);
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) bus.start = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(posedge clk);
            #1;
            if (bus.result_final === 200'd32) got = 1'b1;
        end
        total_cnt++;
        if (!got) $display("FAIL det_after_rst got=%h exp=20 within 64 cycles", bus.result_final);
        else pass_cnt++;
        release_start();
    endtask

    initial begin
        bus.start = 1'b0;
        for (int n = 0; n < 25; n++) begin
            common_a[8*n +: 8] = 8'(n + 1);
            ones_b[8*n +: 8]   = 8'd1;
        end
        test_reset();
        test_add();
        test_sub();
        test_matmul();
        test_scalar();
        test_transpose();
        test_negate();
        test_op_zero();
        test_overflow();
        test_det_rank2();
        test_det_2i_input_change();
        test_det_4i();
        test_det_swap();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
